conv_layer_scheduler: RTL and testbench
=======================================

// Module: conv_layer_scheduler
// PURPOSE
//  Top-level sequencer for one convolution layer on the systolic array. Splits NO_FILTER filters into
//  passes of FILTERS_PER_PASS columns; per pass, loads weights once, then for each of NO_TILE input tiles
//  runs IFM load -> compute -> OFM store. Drives single-cycle load/start pulses to the weight address
//  controller, IFM address controller, array control and OFM writer, and waits on their done pulses.
// PARAMETERS
//  NO_FILTER        64  total filters in the layer
//  FILTERS_PER_PASS 16  filters per pass (array columns); NO_FILTER must be a multiple of it
//  NO_TILE          4   IFM tiles per pass (>=1)
//  CNT_WIDTH        32  width of busy-cycle performance counter
// PORTS
//  clk           in   1   clock, all logic on posedge
//  rst           in   1   synchronous active-high reset
//  start         in   1   pulse: begin layer (accepted only in IDLE)
//  abort         in   1   pulse: return to IDLE next cycle from any state
//  wgt_load      out  1   1-cycle pulse to weight address controller
//  wgt_done      in   1   pulse: weight load finished
//  ifm_load      out  1   1-cycle pulse to IFM address controller
//  ifm_done      in   1   pulse: IFM tile loaded
//  compute_start out  1   1-cycle pulse to array control
//  compute_done  in   1   pulse: array drained
//  ofm_store     out  1   1-cycle pulse to OFM writer
//  ofm_done      in   1   pulse: OFM tile written
//  pass_idx      out  $clog2(NO_FILTER/FILTERS_PER_PASS)+1  current pass, valid while busy
//  tile_idx      out  $clog2(NO_TILE)+1                     current tile, valid while busy
//  busy          out  1   high in every state except IDLE
//  done          out  1   1-cycle pulse on completion of last OFM store
//  busy_cycles   out  CNT_WIDTH  cycles spent busy in the last/current layer
// BEHAVIOUR
//  Reset: state=IDLE; all pulse outputs, busy, done =0; pass_idx=tile_idx=0; busy_cycles=0.
//  States: IDLE, LOAD_WGT, WAIT_WGT, LOAD_IFM, WAIT_IFM, COMPUTE, WAIT_CMP, STORE, WAIT_OFM, FINISH.
//  IDLE: start & !abort -> LOAD_WGT; pass_idx,tile_idx,busy_cycles cleared on acceptance.
//  LOAD_* / COMPUTE / STORE: assert matching pulse for exactly one cycle, go to WAIT_* next cycle.
//  WAIT_WGT: wgt_done -> LOAD_IFM. WAIT_IFM: ifm_done -> COMPUTE. WAIT_CMP: compute_done -> STORE.
//  WAIT_OFM on ofm_done: tile_idx<NO_TILE-1 -> tile_idx+1, LOAD_IFM (weights reused);
//    else tile_idx=0 and pass_idx<NPASS-1 -> pass_idx+1, LOAD_WGT; else FINISH.
//  FINISH: done=1 for one cycle -> IDLE. pass_idx/tile_idx hold last values in IDLE.
//  Pulse outputs are registered: pulse is high in the cycle after entering LOAD_*/COMPUTE/STORE-state decision,
//    i.e. start sampled at edge N -> wgt_load high during cycle N+1.
//  Done inputs arriving in a non-matching state are ignored (no queuing). A done in the same cycle as its
//    own pulse is not accepted; earliest acceptance is the cycle after the pulse.
//  abort: highest priority; next state IDLE, all pulses forced 0, done not asserted, busy_cycles held.
//  start while busy: ignored. start and abort together in IDLE: abort wins, stay IDLE.
//  busy_cycles: +1 every cycle busy=1; saturates at all-ones (no wrap).
//  Total handshakes per layer: NPASS wgt_load, NPASS*NO_TILE each of ifm_load/compute_start/ofm_store.
// STRUCTURE
//  Shared package conv_pkg: state encoding localparams, NPASS=NO_FILTER/FILTERS_PER_PASS, index widths.
//  Sub-module: sched_loop_counter (2-level pass/tile counter with wrap and last flags), instantiated once.
//  FSM, pulse registers and busy_cycles counter in this module.
// TESTING
//  Defaults, all dones returned 3 cycles after pulse: start -> 4 wgt_load, 16 each ifm_load/compute_start/
//    ofm_store, order W,(I,C,O)x4 per pass, single done pulse, pass_idx 0..3, tile_idx 0..3.
//  Same run: busy_cycles at done equals measured cycles from start acceptance to FINISH inclusive.
//  abort during WAIT_CMP of pass 2 tile 1 -> IDLE next cycle, busy=0, no done, no further pulses;
//    fresh start restarts at pass 0 tile 0 with wgt_load.
//  Spurious compute_done during WAIT_IFM and start while busy -> ignored, sequence unchanged.
//  NO_TILE=1, NO_FILTER=16: start -> exactly W,I,C,O then done; start+abort same cycle in IDLE -> no pulse.
//  rst asserted mid-layer for 1 cycle -> all outputs reset values next cycle, no done.

Source files
------------

// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution layer scheduler:
//   - FSM state encodings (plain localparam constants, 4 bits wide)
//   - helpers that derive the pass count and index widths from the layer
//     parameters, so the top level and the loop counter agree on them
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] S_IDLE     = 4'd0;
    localparam logic [STATE_W-1:0] S_LOAD_WGT = 4'd1;
    localparam logic [STATE_W-1:0] S_WAIT_WGT = 4'd2;
    localparam logic [STATE_W-1:0] S_LOAD_IFM = 4'd3;
    localparam logic [STATE_W-1:0] S_WAIT_IFM = 4'd4;
    localparam logic [STATE_W-1:0] S_COMPUTE  = 4'd5;
    localparam logic [STATE_W-1:0] S_WAIT_CMP = 4'd6;
    localparam logic [STATE_W-1:0] S_STORE    = 4'd7;
    localparam logic [STATE_W-1:0] S_WAIT_OFM = 4'd8;
    localparam logic [STATE_W-1:0] S_FINISH   = 4'd9;

    // Number of filter passes needed to cover the whole layer.
    function automatic int num_passes(input int no_filter, input int filters_per_pass);
        return no_filter / filters_per_pass;
    endfunction

    // Index width: one spare bit so a count of 1 still yields a legal 1-bit vector.
    function automatic int idx_width(input int count);
        return $clog2(count) + 1;
    endfunction

endpackage

// File: rtl/sched_loop_counter.sv
// -----------------------------------------------------------------------------
// sched_loop_counter
// Two-level nested loop counter: tile index is the inner loop, pass index the
// outer loop. On advance the tile steps; when the last tile wraps to 0 the pass
// steps, unless it is already the last pass, in which case it holds so the
// final pass number stays visible after the layer ends.
// Ports:
//   clk, rst   clock / synchronous active-high reset
//   clear      zero both indices (new layer accepted)
//   advance    one tile finished
//   pass_idx   current pass
//   tile_idx   current tile
//   last_tile  tile_idx is the final tile of a pass
//   last_pass  pass_idx is the final pass of the layer
// -----------------------------------------------------------------------------
module sched_loop_counter #(
    parameter int NPASS  = 4,
    parameter int NTILE  = 4,
    parameter int PASS_W = 3,
    parameter int TILE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    output logic [PASS_W-1:0] pass_idx,
    output logic [TILE_W-1:0] tile_idx,
    output logic              last_tile,
    output logic              last_pass
);

    logic [PASS_W-1:0] pass_q, pass_d;
    logic [TILE_W-1:0] tile_q, tile_d;

    assign last_tile = (tile_q == TILE_W'(NTILE - 1));
    assign last_pass = (pass_q == PASS_W'(NPASS - 1));

    always_comb begin
        pass_d = pass_q;
        tile_d = tile_q;
        if (clear) begin
            pass_d = '0;
            tile_d = '0;
        end else if (advance) begin
            if (!last_tile) begin
                tile_d = tile_q + 1'b1;
            end else begin
                tile_d = '0;
                if (!last_pass) begin
                    pass_d = pass_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_q <= '0;
            tile_q <= '0;
        end else begin
            pass_q <= pass_d;
            tile_q <= tile_d;
        end
    end

    assign pass_idx = pass_q;
    assign tile_idx = tile_q;

endmodule

// File: rtl/conv_layer_scheduler.sv
// -----------------------------------------------------------------------------
// conv_layer_scheduler
// Sequences one convolution layer on the systolic array: for each filter pass
// the weights are loaded once, then every IFM tile goes through
// IFM load -> compute -> OFM store. Each step is a one-cycle request pulse to a
// helper block followed by a wait for that block's done pulse.
// Ports:
//   clk, rst                    clock / synchronous active-high reset
//   start, abort                begin layer (IDLE only) / return to IDLE at once
//   wgt_load / wgt_done         weight address controller handshake
//   ifm_load / ifm_done         IFM address controller handshake
//   compute_start/compute_done  array control handshake
//   ofm_store / ofm_done        OFM writer handshake
//   pass_idx, tile_idx          loop position, valid while busy
//   busy                        high in every state but IDLE
//   done                        one-cycle pulse after the last OFM store
//   busy_cycles                 saturating count of busy cycles in this layer
// -----------------------------------------------------------------------------
module conv_layer_scheduler
    import conv_pkg::*;
#(
    parameter int NO_FILTER        = 64,
    parameter int FILTERS_PER_PASS = 16,
    parameter int NO_TILE          = 4,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic                                         abort,
    output logic                                         wgt_load,
    input  logic                                         wgt_done,
    output logic                                         ifm_load,
    input  logic                                         ifm_done,
    output logic                                         compute_start,
    input  logic                                         compute_done,
    output logic                                         ofm_store,
    input  logic                                         ofm_done,
    output logic [$clog2(NO_FILTER/FILTERS_PER_PASS):0]  pass_idx,
    output logic [$clog2(NO_TILE):0]                     tile_idx,
    output logic                                         busy,
    output logic                                         done,
    output logic [CNT_WIDTH-1:0]                         busy_cycles
);

    localparam int NPASS  = num_passes(NO_FILTER, FILTERS_PER_PASS);
    localparam int PASS_W = idx_width(NPASS);
    localparam int TILE_W = idx_width(NO_TILE);

    logic [STATE_W-1:0]   state_q, state_d;
    logic                 wgt_load_q, wgt_load_d;
    logic                 ifm_load_q, ifm_load_d;
    logic                 compute_start_q, compute_start_d;
    logic                 ofm_store_q, ofm_store_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [CNT_WIDTH-1:0] busy_cycles_q, busy_cycles_d;
    logic [CNT_WIDTH-1:0] cnt_base;

    logic accept;
    logic advance;
    logic last_tile;
    logic last_pass;

    sched_loop_counter #(
        .NPASS  (NPASS),
        .NTILE  (NO_TILE),
        .PASS_W (PASS_W),
        .TILE_W (TILE_W)
    ) u_loop (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .advance   (advance),
        .pass_idx  (pass_idx),
        .tile_idx  (tile_idx),
        .last_tile (last_tile),
        .last_pass (last_pass)
    );

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_WGT;
                    accept  = 1'b1;
                end
            end
            S_LOAD_WGT: state_d = S_WAIT_WGT;
            S_WAIT_WGT: if (wgt_done)     state_d = S_LOAD_IFM;
            S_LOAD_IFM: state_d = S_WAIT_IFM;
            S_WAIT_IFM: if (ifm_done)     state_d = S_COMPUTE;
            S_COMPUTE:  state_d = S_WAIT_CMP;
            S_WAIT_CMP: if (compute_done) state_d = S_STORE;
            S_STORE:    state_d = S_WAIT_OFM;
            S_WAIT_OFM: begin
                if (ofm_done) begin
                    advance = 1'b1;
                    if (!last_tile) begin
                        state_d = S_LOAD_IFM;     // same weights, next tile
                    end else if (!last_pass) begin
                        state_d = S_LOAD_WGT;     // next filter pass
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a start in IDLE and a pending advance.
        if (abort) begin
            state_d = S_IDLE;
            accept  = 1'b0;
            advance = 1'b0;
        end
    end

    // Outputs are registered from the next state, so each pulse is high exactly
    // during the cycle the FSM sits in the matching request state.
    always_comb begin
        wgt_load_d      = (state_d == S_LOAD_WGT);
        ifm_load_d      = (state_d == S_LOAD_IFM);
        compute_start_d = (state_d == S_COMPUTE);
        ofm_store_d     = (state_d == S_STORE);
        busy_d          = (state_d != S_IDLE);
        done_d          = (state_d == S_FINISH);

        // Count the cycle being entered, so the value shown during FINISH
        // already includes FINISH itself.
        cnt_base      = accept ? '0 : busy_cycles_q;
        busy_cycles_d = cnt_base;
        if (busy_d && (cnt_base != '1)) begin
            busy_cycles_d = cnt_base + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order; reset is
    // synchronous, so it is tested inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            wgt_load_q      <= 1'b0;
            ifm_load_q      <= 1'b0;
            compute_start_q <= 1'b0;
            ofm_store_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            busy_cycles_q   <= '0;
        end else begin
            state_q         <= state_d;
            wgt_load_q      <= wgt_load_d;
            ifm_load_q      <= ifm_load_d;
            compute_start_q <= compute_start_d;
            ofm_store_q     <= ofm_store_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            busy_cycles_q   <= busy_cycles_d;
        end
    end

    assign wgt_load      = wgt_load_q;
    assign ifm_load      = ifm_load_q;
    assign compute_start = compute_start_q;
    assign ofm_store     = ofm_store_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign busy_cycles   = busy_cycles_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_conv_layer_scheduler
// Scoreboard bench. The main instance uses default parameters; a responder
// returns every done 3 cycles after its pulse. Expected pulse sequences are
// queued when a layer is started and popped as pulses appear. A second,
// single-pass single-tile instance checks the minimal W,I,C,O,done sequence.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conv_layer_scheduler;

    localparam int NPASS = 4;
    localparam int NTILE = 4;
    localparam int PW    = 3;
    localparam int TW    = 3;
    localparam int CW    = 32;

    localparam int K_W = 1;
    localparam int K_I = 2;
    localparam int K_C = 3;
    localparam int K_O = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance (defaults) ----------------
    logic rst, start, abort;
    logic wgt_load, ifm_load, compute_start, ofm_store;
    logic wgt_done, ifm_done, compute_done, ofm_done;
    logic busy, done;
    logic [PW-1:0] pass_idx;
    logic [TW-1:0] tile_idx;
    logic [CW-1:0] busy_cycles;

    conv_layer_scheduler u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .wgt_load      (wgt_load),
        .wgt_done      (wgt_done),
        .ifm_load      (ifm_load),
        .ifm_done      (ifm_done),
        .compute_start (compute_start),
        .compute_done  (compute_done),
        .ofm_store     (ofm_store),
        .ofm_done      (ofm_done),
        .pass_idx      (pass_idx),
        .tile_idx      (tile_idx),
        .busy          (busy),
        .done          (done),
        .busy_cycles   (busy_cycles)
    );

    // ---------------- small instance: 1 pass, 1 tile ----------------
    logic s_start, s_abort;
    logic s_wgt_load, s_ifm_load, s_compute_start, s_ofm_store;
    logic s_wgt_done, s_ifm_done, s_compute_done, s_ofm_done;
    logic s_busy, s_done;
    logic [0:0] s_pass_idx;
    logic [0:0] s_tile_idx;
    logic [CW-1:0] s_busy_cycles;

    conv_layer_scheduler #(
        .NO_FILTER        (16),
        .FILTERS_PER_PASS (16),
        .NO_TILE          (1),
        .CNT_WIDTH        (CW)
    ) u_small (
        .clk           (clk),
        .rst           (rst),
        .start         (s_start),
        .abort         (s_abort),
        .wgt_load      (s_wgt_load),
        .wgt_done      (s_wgt_done),
        .ifm_load      (s_ifm_load),
        .ifm_done      (s_ifm_done),
        .compute_start (s_compute_start),
        .compute_done  (s_compute_done),
        .ofm_store     (s_ofm_store),
        .ofm_done      (s_ofm_done),
        .pass_idx      (s_pass_idx),
        .tile_idx      (s_tile_idx),
        .busy          (s_busy),
        .done          (s_done),
        .busy_cycles   (s_busy_cycles)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int kind;
        int pass;
        int tile;
    } exp_t;

    exp_t sb[$];

    task automatic push_layer();
        for (int p = 0; p < NPASS; p++) begin
            sb.push_back('{kind: K_W, pass: p, tile: 0});
            for (int t = 0; t < NTILE; t++) begin
                sb.push_back('{kind: K_I, pass: p, tile: t});
                sb.push_back('{kind: K_C, pass: p, tile: t});
                sb.push_back('{kind: K_O, pass: p, tile: t});
            end
        end
    endtask

    // ---------------- monitor (main instance) ----------------
    int n_w = 0, n_i = 0, n_c = 0, n_o = 0, n_pulse = 0, n_done = 0;
    int meas_total = 0;
    int meas_base  = 0;

    initial begin
        forever begin
            int   code;
            int   hot;
            exp_t e;
            @(negedge clk);
            if (busy === 1'b1) meas_total++;
            hot  = $countones({wgt_load, ifm_load, compute_start, ofm_store});
            code = wgt_load ? K_W : ifm_load ? K_I : compute_start ? K_C : ofm_store ? K_O : 0;
            if (hot > 1) check("pulse_onehot", hot, 1);
            if (code != 0) begin
                n_pulse++;
                case (code)
                    K_W: n_w++;
                    K_I: n_i++;
                    K_C: n_c++;
                    default: n_o++;
                endcase
                if (sb.size() == 0) begin
                    check("unexpected_pulse", code, 0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind", code, e.kind);
                    check("pulse_pass", pass_idx, e.pass);
                    check("pulse_tile", tile_idx, e.tile);
                end
            end
            if (done === 1'b1) begin
                n_done++;
                check("sb_drained_at_done", sb.size(), 0);
                check("busy_cycles_at_done", busy_cycles, meas_total - meas_base);
            end
        end
    end

    // ---------------- responder (main instance) ----------------
    int spur_req = 0;

    initial begin
        int cd_w, cd_i, cd_c, cd_o, spur_ack;
        cd_w = 0; cd_i = 0; cd_c = 0; cd_o = 0; spur_ack = 0;
        wgt_done = 1'b0; ifm_done = 1'b0; compute_done = 1'b0; ofm_done = 1'b0;
        forever begin
            @(negedge clk);
            wgt_done = 1'b0; ifm_done = 1'b0; compute_done = 1'b0; ofm_done = 1'b0;
            if (cd_w > 0) begin cd_w--; if (cd_w == 0) wgt_done     = 1'b1; end
            if (cd_i > 0) begin cd_i--; if (cd_i == 0) ifm_done     = 1'b1; end
            if (cd_c > 0) begin cd_c--; if (cd_c == 0) compute_done = 1'b1; end
            if (cd_o > 0) begin cd_o--; if (cd_o == 0) ofm_done     = 1'b1; end
            if (spur_req != spur_ack) begin
                compute_done = 1'b1;
                spur_ack     = spur_req;
            end
            if (wgt_load)      cd_w = 3;
            if (ifm_load)      cd_i = 3;
            if (compute_start) cd_c = 3;
            if (ofm_store)     cd_o = 3;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_start();
        @(posedge clk); #1;
        start     = 1'b1;
        meas_base = meas_total;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic run_full(input string tag, input bit disturb);
        int  b_done, b_w, b_i, b_c, b_o;
        bit  found;
        b_done = n_done; b_w = n_w; b_i = n_i; b_c = n_c; b_o = n_o;
        push_layer();
        do_start();
        if (disturb) begin
            // Spurious compute_done while waiting on the IFM, plus a start while busy.
            found = 1'b0;
            for (int c = 0; c < 200 && !found; c++) begin
                @(negedge clk);
                if (ifm_load) found = 1'b1;
            end
            check({tag, "_ifm_seen"}, found, 1);
            #1 spur_req++;
            @(posedge clk); #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int c = 0; c < 3000 && n_done == b_done; c++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        check({tag, "_done_count"}, n_done - b_done, 1);
        check({tag, "_n_wgt"}, n_w - b_w, NPASS);
        check({tag, "_n_ifm"}, n_i - b_i, NPASS * NTILE);
        check({tag, "_n_cmp"}, n_c - b_c, NPASS * NTILE);
        check({tag, "_n_ofm"}, n_o - b_o, NPASS * NTILE);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_pass_after"}, pass_idx, NPASS - 1);
    endtask

    task automatic small_run();
        logic [31:0] seq;
        bit          fin;
        logic        pw, pi, pc, po;
        seq = '0; fin = 1'b0; pw = 1'b0; pi = 1'b0; pc = 1'b0; po = 1'b0;
        @(posedge clk); #1;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            // Each done goes out one cycle after its pulse was seen.
            s_wgt_done = pw; s_ifm_done = pi; s_compute_done = pc; s_ofm_done = po;
            pw = s_wgt_load; pi = s_ifm_load; pc = s_compute_start; po = s_ofm_store;
            if (s_wgt_load)      seq = {seq[27:0], 4'h1};
            if (s_ifm_load)      seq = {seq[27:0], 4'h2};
            if (s_compute_start) seq = {seq[27:0], 4'h3};
            if (s_ofm_store)     seq = {seq[27:0], 4'h4};
            if (s_done) begin
                seq = {seq[27:0], 4'h5};
                fin = 1'b1;
            end
        end
        @(negedge clk);
        s_wgt_done = 1'b0; s_ifm_done = 1'b0; s_compute_done = 1'b0; s_ofm_done = 1'b0;
        check("small_done_seen", fin, 1);
        check("small_sequence", seq, 32'h0001_2345);
        // LOAD_WGT, WAIT_WGT, LOAD_IFM, WAIT_IFM, COMPUTE, WAIT_CMP, STORE, WAIT_OFM, FINISH
        check("small_busy_cycles", s_busy_cycles, 9);
        check("small_busy_after", s_busy, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   b_pulse, b_done, act;
        bit   found;
        logic [CW-1:0] held;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        s_start = 1'b0; s_abort = 1'b0;
        s_wgt_done = 1'b0; s_ifm_done = 1'b0; s_compute_done = 1'b0; s_ofm_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pulses", {wgt_load, ifm_load, compute_start, ofm_store}, 0);
        check("rst_pass", pass_idx, 0);
        check("rst_tile", tile_idx, 0);
        check("rst_busy_cycles", busy_cycles, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Normal layer.
        run_full("full", 1'b0);

        // Disturbed layer: spurious done and start while busy are ignored.
        run_full("disturb", 1'b1);

        // Abort during WAIT_CMP of pass 2 tile 1.
        push_layer();
        do_start();
        found = 1'b0;
        for (int c = 0; c < 3000 && !found; c++) begin
            @(negedge clk);
            if (compute_start && pass_idx == 2 && tile_idx == 1) found = 1'b1;
        end
        check("abort_target_seen", found, 1);
        @(posedge clk); #1;
        abort = 1'b1;
        sb.delete();
        b_done = n_done;
        @(posedge clk); #1;
        abort   = 1'b0;
        b_pulse = n_pulse;
        held    = busy_cycles;
        check("abort_busy", busy, 0);
        check("abort_done_low", done, 0);
        repeat (15) @(posedge clk);
        #1;
        check("abort_no_pulses", n_pulse - b_pulse, 0);
        check("abort_no_done", n_done - b_done, 0);
        check("abort_bc_held", busy_cycles, held);

        // Fresh start after abort restarts at pass 0 tile 0 with wgt_load.
        run_full("restart", 1'b0);

        // start and abort together in IDLE: abort wins.
        b_pulse = n_pulse;
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", busy, 0);
        repeat (6) @(posedge clk);
        #1;
        check("start_abort_no_pulse", n_pulse - b_pulse, 0);

        // Reset for one cycle mid-layer.
        push_layer();
        do_start();
        b_done = n_done;
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_pulses", {wgt_load, ifm_load, compute_start, ofm_store}, 0);
        check("midrst_pass", pass_idx, 0);
        check("midrst_tile", tile_idx, 0);
        check("midrst_busy_cycles", busy_cycles, 0);
        b_pulse = n_pulse;
        repeat (15) @(posedge clk);
        #1;
        check("midrst_no_pulse", n_pulse - b_pulse, 0);
        check("midrst_no_done", n_done - b_done, 0);

        // Minimal configuration.
        small_run();
        act = 0;
        @(posedge clk); #1;
        s_start = 1'b1; s_abort = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0; s_abort = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            act += $countones({s_wgt_load, s_ifm_load, s_compute_start, s_ofm_store, s_busy, s_done});
        end
        check("small_start_abort_idle", act, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
